// File: rtl/ib_mul_pkg.sv
// Shared types and constants for the multiplier MAC back end.
// Imported by the accumulation stage and its adder.
package ib_mul_pkg;

  localparam int IB_PROD_W = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } acc_state_e;

endpackage

// File: rtl/ib_mul_acc_add.sv
// Accumulator adder: wide operand plus zero-extended product.
// Separate so carry-chain variants can be dropped in.
module ib_mul_acc_add
  import ib_mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]     i_a,
  input  logic [IB_PROD_W-1:0] i_b,
  output logic [ACC_W-1:0]     o_sum,
  output logic                 o_cout
);

  logic [ACC_W:0] wide_a;
  logic [ACC_W:0] wide_b;
  logic [ACC_W:0] wide_s;

  always_comb begin
    wide_a = {1'b0, i_a};
    wide_b = (ACC_W + 1)'(i_b);
    wide_s = wide_a + wide_b;
  end

  assign o_sum  = wide_s[ACC_W-1:0];
  assign o_cout = wide_s[ACC_W];

endmodule

// File: rtl/ib_mul_acc.sv
// Packet accumulation stage: sums product beats until last,
// then holds sum, beat count and overflow until taken.
module ib_mul_acc
  import ib_mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_vld,
  output logic                 o_rdy,
  input  logic [IB_PROD_W-1:0] i_prod,
  input  logic                 i_last,
  output logic                 o_vld,
  input  logic                 i_rdy,
  output logic [ACC_W-1:0]     o_acc,
  output logic [CNT_W-1:0]     o_cnt,
  output logic                 o_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  logic             accept;
  logic [ACC_W-1:0] add_sum;
  logic             add_cout;

  ib_mul_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_a    (acc_q),
    .i_b    (i_prod),
    .o_sum  (add_sum),
    .o_cout (add_cout)
  );

  assign o_rdy  = !i_rst && (state_q != ST_HOLD);
  assign accept = i_vld && o_rdy;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = ACC_W'(i_prod);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = i_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_cout;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q
                                       : cnt_q + CNT_W'(1);
          state_d = i_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        if (i_rdy) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    vld_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign o_vld = vld_q;
  assign o_acc = acc_q;
  assign o_cnt = cnt_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_ib_mul_acc.sv
// Directed and randomized checks for the packet accumulation stage.
// Inputs change 1ns after the rising edge; outputs are read there.
module tb_ib_mul_acc;

  logic        i_clk;
  logic        i_rst;
  logic        i_vld;
  logic        o_rdy;
  logic [15:0] i_prod;
  logic        i_last;
  logic        o_vld;
  logic        i_rdy;
  logic [23:0] o_acc;
  logic [7:0]  o_cnt;
  logic        o_ovf;

  int checks;
  int failures;

  ib_mul_acc #(
    .ACC_W (24),
    .CNT_W (8)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (i_vld),
    .o_rdy  (o_rdy),
    .i_prod (i_prod),
    .i_last (i_last),
    .o_vld  (o_vld),
    .i_rdy  (i_rdy),
    .o_acc  (o_acc),
    .o_cnt  (o_cnt),
    .o_ovf  (o_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] p, input logic l);
    int  n;
    logic a;
    i_vld  = 1'b1;
    i_prod = p;
    i_last = l;
    n = 0;
    a = 1'b0;
    do begin
      @(negedge i_clk);
      a = o_rdy;
      tick();
      n++;
    end while (!a && n < 200);
    if (!a) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: o_rdy never high in %0d cycles", n);
    end
    i_vld  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic take_result();
    i_rdy = 1'b1;
    tick();
    i_rdy = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_vld, o_acc, o_cnt, o_ovf, o_rdy} !== 35'd0) begin
      failures++;
      $display("FAIL reset_init: vld=%0b acc=%0d cnt=%0d ovf=%0b rdy=%0b want 0",
               o_vld, o_acc, o_cnt, o_ovf, o_rdy);
    end
    i_rst = 1'b0;
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b0);
    checks++;
    if (o_acc !== 24'd300 || o_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_partial: acc=%0d vld=%0b want 300 0", o_acc, o_vld);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy: o_rdy=%0b want 0", o_rdy);
    end
    tick();
    tick();
    checks++;
    if ({o_vld, o_acc, o_cnt, o_ovf} !== 34'd0) begin
      failures++;
      $display("FAIL reset_mid: vld=%0b acc=%0d cnt=%0d ovf=%0b want 0",
               o_vld, o_acc, o_cnt, o_ovf);
    end
    i_rst = 1'b0;
    send_beat(16'd7, 1'b1);
    checks++;
    if (o_vld !== 1'b1 || o_acc !== 24'd7 || o_cnt !== 8'd1) begin
      failures++;
      $display("FAIL reset_next: vld=%0b acc=%0d cnt=%0d want 1 7 1",
               o_vld, o_acc, o_cnt);
    end
    take_result();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) send_beat(16'd65025, 1'b0);
    checks++;
    if (o_vld !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_vld: o_vld=%0b want 0", o_vld);
    end
    send_beat(16'd65025, 1'b1);
    checks++;
    if (o_vld !== 1'b1 || o_acc !== 24'd260100 ||
        o_cnt !== 8'd4 || o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic: vld=%0b acc=%0d cnt=%0d ovf=%0b want 1 260100 4 0",
               o_vld, o_acc, o_cnt, o_ovf);
    end
    take_result();
    checks++;
    if (o_vld !== 1'b0 || o_acc !== 24'd0 || o_rdy !== 1'b1) begin
      failures++;
      $display("FAIL basic_take: vld=%0b acc=%0d rdy=%0b want 0 0 1",
               o_vld, o_acc, o_rdy);
    end
  endtask

  task automatic test_backpressure();
    send_beat(16'd42, 1'b1);
    i_vld  = 1'b1;
    i_prod = 16'd9;
    i_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_vld !== 1'b1 || o_acc !== 24'd42 ||
          o_cnt !== 8'd1 || o_rdy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: vld=%0b acc=%0d cnt=%0d rdy=%0b want 1 42 1 0",
                 i, o_vld, o_acc, o_cnt, o_rdy);
      end
    end
    take_result();
    checks++;
    if (o_vld !== 1'b0 || o_acc !== 24'd0 || o_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_bubble: vld=%0b acc=%0d rdy=%0b want 0 0 1",
               o_vld, o_acc, o_rdy);
    end
    tick();
    i_vld  = 1'b0;
    i_last = 1'b0;
    checks++;
    if (o_vld !== 1'b1 || o_acc !== 24'd9 || o_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bp_accept: vld=%0b acc=%0d cnt=%0d want 1 9 1",
               o_vld, o_acc, o_cnt);
    end
    take_result();
  endtask

  task automatic test_gaps();
    send_beat(16'd1, 1'b0);
    tick();
    tick();
    send_beat(16'd2, 1'b0);
    tick();
    tick();
    checks++;
    if (o_acc !== 24'd3 || o_cnt !== 8'd2 || o_vld !== 1'b0) begin
      failures++;
      $display("FAIL gaps_mid: acc=%0d cnt=%0d vld=%0b want 3 2 0",
               o_acc, o_cnt, o_vld);
    end
    send_beat(16'd3, 1'b1);
    checks++;
    if (o_vld !== 1'b1 || o_acc !== 24'd6 || o_cnt !== 8'd3) begin
      failures++;
      $display("FAIL gaps: vld=%0b acc=%0d cnt=%0d want 1 6 3",
               o_vld, o_acc, o_cnt);
    end
    take_result();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 259; i++) send_beat(16'd65025, i == 258);
    checks++;
    if (o_vld !== 1'b1 || o_acc !== 24'd64259 ||
        o_cnt !== 8'd255 || o_ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow: vld=%0b acc=%0d cnt=%0d ovf=%0b want 1 64259 255 1",
               o_vld, o_acc, o_cnt, o_ovf);
    end
    take_result();
    send_beat(16'd0, 1'b0);
    send_beat(16'd5, 1'b1);
    checks++;
    if (o_vld !== 1'b1 || o_acc !== 24'd5 ||
        o_cnt !== 8'd2 || o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear_zero: vld=%0b acc=%0d cnt=%0d ovf=%0b want 1 5 2 0",
               o_vld, o_acc, o_cnt, o_ovf);
    end
    take_result();
    send_beat(16'd5, 1'b1);
    checks++;
    if (o_acc !== 24'd5 || o_cnt !== 8'd1 || o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: acc=%0d cnt=%0d ovf=%0b want 5 1 0",
               o_acc, o_cnt, o_ovf);
    end
    take_result();
  endtask

  task automatic test_random();
    int          len;
    int          bad;
    longint      sum;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [23:0] exp_acc;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      len = $urandom_range(1, 20);
      sum = 0;
      for (int j = 0; j < len; j++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        p = 16'(a) * 16'(b);
        sum += longint'(p);
        repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) tick();
        send_beat(p, j == len - 1);
      end
      exp_acc = sum[23:0];
      exp_cnt = 8'(len);
      exp_ovf = (sum > 64'd16777215);
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (o_vld !== 1'b1 || o_acc !== exp_acc ||
          o_cnt !== exp_cnt || o_ovf !== exp_ovf) begin
        failures++;
        if (bad < 10)
          $display("FAIL random pkt %0d: vld=%0b acc=%0d cnt=%0d ovf=%0b want 1 %0d %0d %0b",
                   k, o_vld, o_acc, o_cnt, o_ovf, exp_acc, exp_cnt, exp_ovf);
        bad++;
      end
      take_result();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst    = 1'b1;
    i_vld    = 1'b0;
    i_prod   = '0;
    i_last   = 1'b0;
    i_rdy    = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ib_mul_acc.md
Name: ib_mul_acc

Overview:
- Downstream accumulation stage for the 8x8 combinational multipliers (16-bit product output).
- Consumes a stream of 16-bit products delimited by a last flag.
- Sums each packet into a wide accumulator.
- Presents the registered total with beat count and overflow flag over a valid/ready handshake.
- Used as the sequential back end when benchmarking the multiplier variants as a MAC.

Parameters:
- ACC_W, 24: accumulator/result width in bits; must be >= 16.
- CNT_W, 8: beat-counter width in bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_vld  input  1  product beat valid.
- o_rdy  output  1  stage can accept a product beat.
- i_prod  input  16  unsigned product (multiplier o_c).
- i_last  input  1  beat is the final one of the packet; qualified by i_vld.
- o_vld  output  1  result valid.
- i_rdy  input  1  downstream accepts the result.
- o_acc  output  ACC_W  packet sum, registered.
- o_cnt  output  CNT_W  number of beats in the packet, registered.
- o_ovf  output  1  sum exceeded 2^ACC_W-1 during the packet, registered.

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - i_rst is synchronous and active-high. While it is sampled high, state goes to IDLE and all output registers are cleared: o_vld=0, o_acc=0, o_cnt=0, o_ovf=0.
  - o_rdy=0 while i_rst=1.
- States: IDLE, ACC, HOLD.
- Handshake:
  - o_rdy = !i_rst && state!=HOLD (combinational from state only, no dependence on i_vld).
  - A beat is accepted when i_vld && o_rdy.
  - A result is taken when o_vld && i_rdy.
- IDLE:
  - acc=0, cnt=0, ovf=0.
  - Accept without i_last: acc<=i_prod, cnt<=1, go to ACC.
  - Accept with i_last: load the same values, go to HOLD.
- ACC:
  - Accept: acc<=acc+i_prod modulo 2^ACC_W. ovf<=ovf | carry-out. cnt<=cnt+1, saturating at 2^CNT_W-1.
  - With i_last, go to HOLD; otherwise stay in ACC.
  - No accept: all state holds (idle gaps are allowed mid-packet).
- HOLD:
  - o_vld=1; o_acc, o_cnt and o_ovf are stable and unchanged while i_rdy=0.
  - i_rdy=1: go to IDLE and clear acc, cnt and ovf. o_vld=0 on the next cycle.
- Latency:
  - Last beat accepted in cycle N gives o_vld=1 in cycle N+1, with the sum including that beat.
  - Minimum turnaround is one bubble: the next packet's first beat can be accepted no earlier than the cycle after the result is taken.
- Boundaries:
  - Single-beat packet: o_acc=i_prod, o_cnt=1.
  - Zero products count as beats.
  - A beat offered while o_rdy=0 is not consumed; the source must hold it.
  - Reset mid-packet or during HOLD discards the partial or pending result with no o_vld pulse.
  - Overflow wraps the sum and sets the sticky ovf; ovf is reported with the packet and cleared on return to IDLE.
  - Counter saturation does not affect acc.
- Outputs come directly from registers: no combinational path from i_prod to o_acc.

Decomposition:
- Shared package ib_mul_pkg:
  - State typedef (IDLE/ACC/HOLD).
  - IB_PROD_W=16 constant.
  - Default ACC_W/CNT_W constants.
- One sub-module ib_mul_acc_add: ACC_W-bit adder with zero-extended 16-bit operand and carry-out. Kept separate so the adder can be swapped for carry-chain variants.
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset: hold i_rst 2 cycles mid-packet after beats 100, 200 -> o_vld=0, o_acc=0, o_cnt=0, o_ovf=0, o_rdy=0 during reset. The next packet of a single beat 7 (last) -> o_acc=7, o_cnt=1.
- Basic packet: 4 back-to-back beats of 65025 (255*255), last on the 4th -> o_vld one cycle later, o_acc=260100, o_cnt=4, o_ovf=0.
- Backpressure: hold i_rdy=0 for 3 cycles with a result pending -> o_vld/o_acc stable, o_rdy=0. An offered beat is not consumed and is accepted after the i_rdy handshake plus one bubble.
- Gaps: beats 1, 2, 3 with 2 idle cycles between each, last on 3 -> o_acc=6, o_cnt=3.
- Overflow/saturation: 259 beats of 65025 -> o_acc=64259 (wrapped), o_ovf=1, o_cnt=255. The following packet with single beat 5 -> o_ovf=0, o_cnt=1.
- Random: 1000 packets of random length 1..20 with random i_vld/i_rdy gaps and products from random 8-bit a*b -> scoreboard matches sum mod 2^24, count and overflow.
